// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write-port bundle for the program loader.
// The slave modport is the loader itself; the master modport is whoever feeds it.
interface prog_loader_if #(
    parameter int LEN_DATA = 16,
    parameter int LEN_ADDR = 11
);
    logic                i_start;
    logic [7:0]          i_rx_data;
    logic                i_rx_valid;
    logic                o_mem_we;
    logic [LEN_ADDR-1:0] o_mem_addr;
    logic [LEN_DATA-1:0] o_mem_wdata;
    logic                o_cpu_reset;
    logic                o_busy;
    logic                o_done;
    logic                o_error;
    logic [LEN_ADDR:0]   o_words_loaded;

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_reset,
               o_busy, o_done, o_error, o_words_loaded
    );

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_reset,
               o_busy, o_done, o_error, o_words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Fills the BIP program memory from a framed byte stream:
// LEN_HI, LEN_LO, N x {W_HI, W_LO}, CHK (XOR of all preceding bytes).
module prog_loader #(
    parameter int LEN_DATA  = 16,
    parameter int LEN_ADDR  = 11,
    parameter int RAM_DEPTH = 2048
) (
    input  logic          i_clk,
    input  logic          i_reset,
    prog_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    logic [7:0]            r_chk;
    logic [7:0]            r_len_hi;
    logic [7:0]            r_data_hi;
    logic [15:0]           r_len;
    logic [LEN_ADDR:0]     r_count;
    logic                  r_mem_we;
    logic [LEN_ADDR-1:0]   r_mem_addr;
    logic [LEN_DATA-1:0]   r_mem_wdata;
    logic                  r_cpu_reset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic [15:0]           w_len;
    logic [LEN_ADDR:0]     w_count_next;
    logic [7:0]            w_chk_next;

    assign w_len        = {r_len_hi, bus.i_rx_data};
    assign w_count_next = r_count + 1'b1;
    assign w_chk_next   = r_chk ^ bus.i_rx_data;

    // Status flags are registered alongside every state change so they never glitch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_chk       <= '0;
            r_len_hi    <= '0;
            r_data_hi   <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.i_start) begin
                        r_state     <= S_LEN_HI;
                        r_chk       <= '0;
                        r_count     <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (bus.i_rx_valid) begin
                        r_len_hi <= bus.i_rx_data;
                        r_chk    <= w_chk_next;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (bus.i_rx_valid) begin
                        r_len <= w_len;
                        r_chk <= w_chk_next;
                        if (w_len == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if (w_len > 16'(RAM_DEPTH)) begin
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (bus.i_rx_valid) begin
                        r_data_hi <= bus.i_rx_data;
                        r_chk     <= w_chk_next;
                        r_state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (bus.i_rx_valid) begin
                        r_chk       <= w_chk_next;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_count[LEN_ADDR-1:0];
                        r_mem_wdata <= {r_data_hi, bus.i_rx_data};
                        r_count     <= w_count_next;
                        if (16'(w_count_next) == r_len) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_CHECK: begin
                    if (bus.i_rx_valid) begin
                        r_busy <= 1'b0;
                        if (bus.i_rx_data == r_chk) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The CPU must also be held while the loader itself is being reset.
    assign bus.o_cpu_reset    = r_cpu_reset | i_reset;
    assign bus.o_mem_we       = r_mem_we;
    assign bus.o_mem_addr     = r_mem_addr;
    assign bus.o_mem_wdata    = r_mem_wdata;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
    assign bus.o_error        = r_error;
    assign bus.o_words_loaded = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good frame, bad checksum, length overflow,
// empty and full-depth frames, reset mid-load, ignored start/bytes.
module tb_prog_loader;

    logic i_clk;
    logic i_reset;

    prog_loader_if #(.LEN_DATA(16), .LEN_ADDR(11)) bus ();

    prog_loader #(.LEN_DATA(16), .LEN_ADDR(11), .RAM_DEPTH(2048)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    int vectorCount = 0;
    int missCount   = 0;
    logic [7:0]  chk;
    logic [15:0] word;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; the byte is captured on the next rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge i_clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input logic [10:0] addr,
                              input logic [15:0] data, input logic [11:0] words);
        checkOutput({tag, "_we"},    32'(bus.o_mem_we),       32'd1);
        checkOutput({tag, "_addr"},  32'(bus.o_mem_addr),     32'(addr));
        checkOutput({tag, "_data"},  32'(bus.o_mem_wdata),    32'(data));
        checkOutput({tag, "_words"}, 32'(bus.o_words_loaded), 32'(words));
    endtask

    task automatic checkFlags(input string tag, input logic busy, input logic done,
                              input logic err, input logic cpuRst);
        checkOutput({tag, "_busy"},  32'(bus.o_busy),      32'(busy));
        checkOutput({tag, "_done"},  32'(bus.o_done),      32'(done));
        checkOutput({tag, "_error"}, 32'(bus.o_error),     32'(err));
        checkOutput({tag, "_cpu"},   32'(bus.o_cpu_reset), 32'(cpuRst));
    endtask

    initial begin
        i_reset        = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;

        // Reset values
        @(negedge i_clk);
        checkFlags("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_we",    32'(bus.o_mem_we),       32'd0);
        checkOutput("rst_addr",  32'(bus.o_mem_addr),     32'd0);
        checkOutput("rst_wdata", 32'(bus.o_mem_wdata),    32'd0);
        checkOutput("rst_words", 32'(bus.o_words_loaded), 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        checkFlags("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Bytes in IDLE are discarded
        applyStimulus(8'h55);
        applyStimulus(8'hAA);
        checkFlags("idle_rx", 1'b0, 1'b0, 1'b0, 1'b0);

        // Scenario 1: good two-word frame, checksum 00^02^12^34^AB^CD = 42h
        pulseStart();
        checkFlags("s1_start", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        checkOutput("s1_hi_we", 32'(bus.o_mem_we), 32'd0);
        applyStimulus(8'h34);
        checkWrite("s1_w0", 11'd0, 16'h1234, 12'd1);
        applyStimulus(8'hAB);
        checkOutput("s1_hold_we",   32'(bus.o_mem_we),   32'd0);
        checkOutput("s1_hold_addr", 32'(bus.o_mem_addr), 32'd0);
        applyStimulus(8'hCD);
        checkWrite("s1_w1", 11'd1, 16'hABCD, 12'd2);
        applyStimulus(8'h42);
        checkFlags("s1_end", 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s1_words", 32'(bus.o_words_loaded), 32'd2);

        // Bytes in DONE are discarded
        applyStimulus(8'h00);
        checkFlags("done_rx", 1'b0, 1'b1, 1'b0, 1'b0);

        // Scenario 2: same frame with bad checksum
        pulseStart();
        checkOutput("s2_clr_words", 32'(bus.o_words_loaded), 32'd0);
        checkFlags("s2_start", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkWrite("s2_w0", 11'd0, 16'h1234, 12'd1);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        checkWrite("s2_w1", 11'd1, 16'hABCD, 12'd2);
        applyStimulus(8'h00);
        checkFlags("s2_end", 1'b0, 1'b0, 1'b1, 1'b1);

        // Scenario 3: N = 0801h exceeds depth, error right after length
        pulseStart();
        checkFlags("s3_start", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h08);
        applyStimulus(8'h01);
        checkFlags("s3_err", 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("s3_we0", 32'(bus.o_mem_we), 32'd0);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkOutput("s3_we1", 32'(bus.o_mem_we), 32'd0);
        checkFlags("s3_ignored", 1'b0, 1'b0, 1'b1, 1'b1);

        // Scenario 4: empty frame, checksum of 00 00 is 00
        pulseStart();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkOutput("s4_we", 32'(bus.o_mem_we), 32'd0);
        checkFlags("s4_check", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00);
        checkFlags("s4_end", 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s4_words", 32'(bus.o_words_loaded), 32'd0);

        // Scenario 5: reset mid-load, then rerun
        pulseStart();
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        i_reset = 1'b1;
        #1;
        checkFlags("s5_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("s5_rst_words", 32'(bus.o_words_loaded), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checkFlags("s5_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Scenario 6: start with a same-cycle byte (byte dropped), start during DATA_HI ignored
        bus.i_rx_data  = 8'hFF;
        bus.i_rx_valid = 1'b1;
        pulseStart();
        bus.i_rx_valid = 1'b0;
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        pulseStart();
        checkFlags("s6_ign", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkWrite("s6_w0", 11'd0, 16'h1234, 12'd1);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        checkWrite("s6_w1", 11'd1, 16'hABCD, 12'd2);
        applyStimulus(8'h42);
        checkFlags("s6_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // Full depth: N = 0800h, last write lands at 7FFh
        pulseStart();
        chk = 8'h08;
        applyStimulus(8'h08);
        applyStimulus(8'h00);
        word = 16'h0000;
        for (int i = 0; i < 2048; i++) begin
            word = 16'(i) ^ 16'h5A3C;
            chk  = chk ^ word[15:8] ^ word[7:0];
            applyStimulus(word[15:8]);
            applyStimulus(word[7:0]);
        end
        checkWrite("full_last", 11'h7FF, 16'h07FF ^ 16'h5A3C, 12'h800);
        applyStimulus(chk);
        checkFlags("full_end", 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("full_words", 32'(bus.o_words_loaded), 32'h800);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
